// File: rtl/noc_flit_sink.sv
// noc_flit_sink: ejection-side flit receiver for the spidergon NoC.
// Reassembles HEAD/BODY/TAIL and single-flit HEADER packets into a
// descriptor (source, length, payload checksum) and flags protocol errors.
// Optional: define NOC_SINK_STATS_EN to add stat_pkts / stat_errs counters.
module noc_flit_sink #(
  parameter int unsigned NUM_OF_NODES    = 8,
  parameter int unsigned FLIT_DATA_WIDTH = 16,
  parameter int unsigned MAX_PKT_FLITS   = 8,
  localparam int unsigned SRC_W            = $clog2(NUM_OF_NODES),
  localparam int unsigned FLIT_TOTAL_WIDTH = FLIT_DATA_WIDTH + 2,
  localparam int unsigned LEN_W            = $clog2(MAX_PKT_FLITS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [FLIT_TOTAL_WIDTH-1:0] flit_in,
  input  logic                        flit_valid,
  output logic                        flit_ready,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic [SRC_W-1:0]            pkt_src,
  output logic [LEN_W-1:0]            pkt_len,
  output logic [FLIT_DATA_WIDTH-1:0]  pkt_sum,
  output logic                        err_orphan,
  output logic                        err_trunc,
  output logic                        err_overflow
`ifdef NOC_SINK_STATS_EN
  ,
  output logic [31:0]                 stat_pkts,
  output logic [15:0]                 stat_errs
`endif
);

  typedef enum logic {IDLE, PAYLOAD} state_t;
  typedef enum logic [1:0] {
    FT_TAIL   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_BODY   = 2'b10,
    FT_HEADER = 2'b11
  } flit_type_t;

  state_t                     state;
  logic [SRC_W-1:0]           cur_src;
  logic [LEN_W-1:0]           cur_len;
  logic [FLIT_DATA_WIDTH-1:0] cur_sum;

  flit_type_t                 ftype;
  logic [FLIT_DATA_WIDTH-1:0] payload;
  logic                       accept;
  logic [LEN_W-1:0]           len_inc;
  logic [FLIT_DATA_WIDTH-1:0] sum_inc;

  assign ftype      = flit_type_t'(flit_in[FLIT_TOTAL_WIDTH-1 -: 2]);
  assign payload    = flit_in[FLIT_DATA_WIDTH-1:0];
  // The descriptor register can take a new packet only when empty or draining.
  assign flit_ready = reset & (~pkt_valid | pkt_ready);
  assign accept     = flit_valid & flit_ready;
  assign len_inc    = cur_len + LEN_W'(1);
  assign sum_inc    = cur_sum + payload;

  // Packet reassembly FSM, descriptor register and error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cur_src      <= '0;
      cur_len      <= '0;
      cur_sum      <= '0;
      pkt_valid    <= 1'b0;
      pkt_src      <= '0;
      pkt_len      <= '0;
      pkt_sum      <= '0;
      err_orphan   <= 1'b0;
      err_trunc    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_orphan   <= 1'b0;
      err_trunc    <= 1'b0;
      err_overflow <= 1'b0;
      if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;
      // Completions only happen on accepted flits, and acceptance implies the
      // descriptor is empty or consumed, so a completion here may overwrite it.
      if (accept) begin
        case (ftype)
          FT_HEADER: begin
            if (state == PAYLOAD) err_trunc <= 1'b1;
            pkt_valid <= 1'b1;
            pkt_src   <= payload[SRC_W-1:0];
            pkt_len   <= LEN_W'(1);
            pkt_sum   <= '0;
            cur_len   <= '0;
            cur_sum   <= '0;
            state     <= IDLE;
          end
          FT_HEAD: begin
            if (state == PAYLOAD) err_trunc <= 1'b1;
            cur_src <= payload[SRC_W-1:0];
            cur_len <= LEN_W'(1);
            cur_sum <= '0;
            state   <= PAYLOAD;
          end
          FT_BODY: begin
            if (state == IDLE) begin
              err_orphan <= 1'b1;
            end else if (len_inc == LEN_W'(MAX_PKT_FLITS)) begin
              // A BODY filling the last slot leaves no room for the TAIL.
              err_overflow <= 1'b1;
              cur_len      <= '0;
              cur_sum      <= '0;
              state        <= IDLE;
            end else begin
              cur_len <= len_inc;
              cur_sum <= sum_inc;
            end
          end
          default: begin
            if (state == IDLE) begin
              err_orphan <= 1'b1;
            end else begin
              pkt_valid <= 1'b1;
              pkt_src   <= cur_src;
              pkt_len   <= len_inc;
              pkt_sum   <= sum_inc;
              cur_len   <= '0;
              cur_sum   <= '0;
              state     <= IDLE;
            end
          end
        endcase
      end
    end
  end

`ifdef NOC_SINK_STATS_EN
  // Saturating counters of consumed descriptors and error pulses; at most one
  // error pulse is raised per cycle, so a single increment suffices.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_pkts <= '0;
      stat_errs <= '0;
    end else begin
      if (pkt_valid && pkt_ready && (stat_pkts != '1))
        stat_pkts <= stat_pkts + 32'd1;
      if ((err_orphan || err_trunc || err_overflow) && (stat_errs != '1))
        stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_flit_sink.sv
// Directed self-checking bench for noc_flit_sink (default build).
module tb_noc_flit_sink;

  localparam logic [1:0] T_TAIL   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_HEADER = 2'b11;

  logic        clk;
  logic        reset;
  logic [17:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [2:0]  pkt_src;
  logic [3:0]  pkt_len;
  logic [15:0] pkt_sum;
  logic        err_orphan;
  logic        err_trunc;
  logic        err_overflow;

  int checks   = 0;
  int failures = 0;

  noc_flit_sink #(
    .NUM_OF_NODES(8),
    .FLIT_DATA_WIDTH(16),
    .MAX_PKT_FLITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flit_in(flit_in),
    .flit_valid(flit_valid),
    .flit_ready(flit_ready),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_src(pkt_src),
    .pkt_len(pkt_len),
    .pkt_sum(pkt_sum),
    .err_orphan(err_orphan),
    .err_trunc(err_trunc),
    .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one flit for one clock edge; outputs are sampled 1 time unit later.
  task automatic send(input logic [1:0] t, input logic [15:0] p);
    flit_in    = {t, p};
    flit_valid = 1'b1;
    @(posedge clk); #1;
    flit_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic chk_desc(input string tag, input logic v, input logic [2:0] s,
                          input logic [3:0] l, input logic [15:0] sm);
    chk({tag, "_valid"}, 32'(pkt_valid), 32'(v));
    chk({tag, "_src"},   32'(pkt_src),   32'(s));
    chk({tag, "_len"},   32'(pkt_len),   32'(l));
    chk({tag, "_sum"},   32'(pkt_sum),   32'(sm));
  endtask

  task automatic chk_err(input string tag, input logic o, input logic t, input logic v);
    chk({tag, "_orphan"},   32'(err_orphan),   32'(o));
    chk({tag, "_trunc"},    32'(err_trunc),    32'(t));
    chk({tag, "_overflow"}, 32'(err_overflow), 32'(v));
  endtask

  initial begin
    reset      = 1'b0;
    flit_in    = '0;
    flit_valid = 1'b0;
    pkt_ready  = 1'b1;

    // Reset state
    idle(); idle();
    chk_desc("rst", 1'b0, 3'd0, 4'd0, 16'h0000);
    chk_err("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_flit_ready", 32'(flit_ready), 32'd0);
    reset = 1'b1; #1;
    chk("rel_flit_ready", 32'(flit_ready), 32'd1);

    // Single-flit HEADER
    send(T_HEADER, 16'h0003);
    chk_desc("hdr", 1'b1, 3'd3, 4'd1, 16'h0000);
    idle();
    chk("hdr_drop", 32'(pkt_valid), 32'd0);

    // HEAD/BODY/BODY/TAIL with checksum wrap; upper head bits ignored
    send(T_HEAD, 16'hFF05);
    chk("p4_head_nv", 32'(pkt_valid), 32'd0);
    send(T_BODY, 16'h0010);
    send(T_BODY, 16'hFFF8);
    chk("p4_body_nv", 32'(pkt_valid), 32'd0);
    send(T_TAIL, 16'h0001);
    chk_desc("p4", 1'b1, 3'd5, 4'd4, 16'h0009);
    chk_err("p4", 1'b0, 1'b0, 1'b0);
    idle();
    chk("p4_drop", 32'(pkt_valid), 32'd0);

    // Orphan BODY, then a normal HEADER
    send(T_BODY, 16'h1234);
    chk_err("orph", 1'b1, 1'b0, 1'b0);
    chk("orph_nv", 32'(pkt_valid), 32'd0);
    send(T_HEADER, 16'h0002);
    chk_err("orph2", 1'b0, 1'b0, 1'b0);
    chk_desc("orph2", 1'b1, 3'd2, 4'd1, 16'h0000);
    idle();

    // Truncation by HEADER
    send(T_HEAD, 16'h0001);
    send(T_BODY, 16'h0007);
    send(T_HEADER, 16'h0006);
    chk_err("trunc", 1'b0, 1'b1, 1'b0);
    chk_desc("trunc", 1'b1, 3'd6, 4'd1, 16'h0000);
    idle();
    chk("trunc_drop", 32'(pkt_valid), 32'd0);
    chk("trunc_pulse", 32'(err_trunc), 32'd0);

    // Overflow: HEAD + 7 BODY
    send(T_HEAD, 16'h0000);
    for (int i = 0; i < 6; i++) send(T_BODY, 16'h0001);
    chk_err("ovf6", 1'b0, 1'b0, 1'b0);
    send(T_BODY, 16'h0001);
    chk_err("ovf7", 1'b0, 1'b0, 1'b1);
    chk("ovf7_nv", 32'(pkt_valid), 32'd0);
    idle();
    chk("ovf_pulse", 32'(err_overflow), 32'd0);
    chk("ovf_nv2", 32'(pkt_valid), 32'd0);
    send(T_TAIL, 16'h0005);
    chk("ovf_idle_orphan", 32'(err_orphan), 32'd1);

    // Max-length packet with consumer stalled afterwards
    pkt_ready = 1'b0;
    send(T_HEAD, 16'h0004);
    for (int i = 1; i <= 6; i++) send(T_BODY, 16'(i));
    send(T_TAIL, 16'h0100);
    chk_desc("max", 1'b1, 3'd4, 4'd8, 16'h0115);
    chk_err("max", 1'b0, 1'b0, 1'b0);
    flit_in    = {T_HEADER, 16'h0007};
    flit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready", 32'(flit_ready), 32'd0);
      idle();
      chk_desc("stall", 1'b1, 3'd4, 4'd8, 16'h0115);
    end
    pkt_ready = 1'b1; #1;
    chk("unstall_ready", 32'(flit_ready), 32'd1);
    idle();
    flit_valid = 1'b0;
    chk_desc("unstall", 1'b1, 3'd7, 4'd1, 16'h0000);
    idle();
    chk("unstall_drop", 32'(pkt_valid), 32'd0);

    // Reset mid-packet
    send(T_HEAD, 16'h0003);
    send(T_BODY, 16'h0009);
    reset = 1'b0;
    idle();
    chk_desc("mrst", 1'b0, 3'd0, 4'd0, 16'h0000);
    chk_err("mrst", 1'b0, 1'b0, 1'b0);
    chk("mrst_flit_ready", 32'(flit_ready), 32'd0);
    reset = 1'b1;
    send(T_TAIL, 16'h0002);
    chk("mrst_orphan", 32'(err_orphan), 32'd1);
    chk("mrst_nv", 32'(pkt_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
